udma_hyper_ch_sched: RTL

- Transaction scheduler placed between the per-channel (multi-ID) hyperbus configuration slices and the single shared hyperbus PHY transaction port.
- Accepts one transfer request per channel and arbitrates between channels round-robin.
- Splits each accepted transfer into PHY bursts that never cross a MAX_BURST-aligned boundary.
- Issues the bursts sequentially and pulses a per-channel end-of-transfer event when the last burst completes.

---
 rtl/udma_hyper_ch_sched_if.sv | 27 ++
 rtl/udma_hyper_ch_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/udma_hyper_ch_sched_if.sv
// Hyperbus PHY transaction port between the channel scheduler and the PHY.
// The scheduler is the master: it drives burst requests and sees ready/done.
interface udma_hyper_ch_sched_if #(
    parameter int NB_CH      = 8,
    parameter int TRANS_SIZE = 16,
    parameter int ADDR_W     = 32
);
    localparam int ID_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;

    logic                  valid;
    logic                  ready;
    logic [ADDR_W-1:0]     addr;
    logic [TRANS_SIZE-1:0] size;
    logic                  rwn;
    logic [ID_W-1:0]       id;
    logic                  done;

    modport master (
        output valid, addr, size, rwn, id,
        input  ready, done
    );

    modport slave (
        input  valid, addr, size, rwn, id,
        output ready, done
    );
endinterface

// File: rtl/udma_hyper_ch_sched.sv
// Round-robin scheduler from the hyperbus channel slices onto the shared PHY.
// Each transfer is cut into bursts that never cross a MAX_BURST boundary.
module udma_hyper_ch_sched #(
    parameter int NB_CH      = 8,
    parameter int TRANS_SIZE = 16,
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 1024
) (
    input  logic                             sys_clk_i,
    input  logic                             rstn_i,
    input  logic [NB_CH-1:0]                 ch_req_i,
    input  logic [NB_CH-1:0]                 ch_rwn_i,
    input  logic [NB_CH-1:0][ADDR_W-1:0]     ch_addr_i,
    input  logic [NB_CH-1:0][TRANS_SIZE-1:0] ch_size_i,
    output logic [NB_CH-1:0]                 ch_gnt_o,
    udma_hyper_ch_sched_if.master            phy,
    output logic [NB_CH-1:0]                 evt_eot_o,
    output logic                             busy_o
);
    localparam int ID_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        EOT
    } state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TRANS_SIZE-1:0] rem_q, rem_d;
    logic [TRANS_SIZE-1:0] burst_q, burst_d;
    logic                  rwn_q, rwn_d;

    logic [NB_CH-1:0]      gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_found;
    logic [ID_W-1:0]       idx;
    logic [TRANS_SIZE:0]   room;
    logic [TRANS_SIZE-1:0] burst;

    // Search upward from the channel after the last winner, with wrap-around.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NB_CH; i++) begin
            idx = ID_W'((int'(last_q) + i) % NB_CH);
            if (!gnt_found && ch_req_i[idx]) begin
                gnt_found = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    // Room left in the current window is at most MAX_BURST, so one extra bit suffices.
    always_comb begin
        room  = (TRANS_SIZE+1)'(MAX_BURST)
              - (TRANS_SIZE+1)'(addr_q & ADDR_W'(MAX_BURST - 1));
        burst = ({1'b0, rem_q} < room) ? rem_q : room[TRANS_SIZE-1:0];
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        rwn_d     = rwn_q;
        ch_gnt_o  = '0;
        evt_eot_o = '0;
        phy.valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                ch_gnt_o = gnt & {NB_CH{rstn_i}};
                if (gnt_found) begin
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    addr_d  = ch_addr_i[gnt_id];
                    rem_d   = ch_size_i[gnt_id];
                    rwn_d   = ch_rwn_i[gnt_id];
                    state_d = (ch_size_i[gnt_id] != '0) ? ISSUE : EOT;
                end
            end
            ISSUE: begin
                phy.valid = 1'b1;
                if (phy.ready) begin
                    burst_d = burst;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (phy.done) begin
                    addr_d  = addr_q + ADDR_W'(burst_q);
                    rem_d   = rem_q - burst_q;
                    state_d = (rem_q == burst_q) ? EOT : ISSUE;
                end
            end
            EOT: begin
                evt_eot_o[id_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign phy.addr = addr_q;
    assign phy.size = burst;
    assign phy.rwn  = rwn_q;
    assign phy.id   = id_q;
    assign busy_o   = (state_q != IDLE);

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NB_CH - 1);
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            rwn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            burst_q <= burst_d;
            rwn_q   <= rwn_d;
        end
    end
endmodule
